// File: rtl/mux4_rr_ctl_pkg.sv
// mux4_rr_ctl_pkg: state encodings and counter widths shared by the mux scheduler.
package mux4_rr_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int SETUP_W = 4;
    localparam int HOLD_W  = 8;

endpackage

// File: rtl/mux4_rr_ctl_pick.sv
// rr_pick4: round-robin pick of the first requester after last, wrapping back to last.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] sel,
    output logic       any
);

    logic [3:0] rot;
    logic [1:0] off;

    always_comb begin
        rot = 4'({req, req} >> (3'(last) + 3'd1));
        off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    end

    assign sel = last + 2'd1 + off;
    assign any = |req;

endmodule

// File: rtl/mux4_rr_ctl.sv
// mux4_rr_ctl: round-robin sharing of an inverting 4:1 mux with break-before-make
// sequencing of the select lines and the active-low strobe.
module mux4_rr_ctl
    import mux4_rr_ctl_pkg::*;
#(
    parameter int SETUP_CYCLES = 1,
    parameter int MAX_HOLD     = 8,
    parameter int TCO          = 0
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [3:0] req,
    output logic       a1,
    output logic       a0,
    output logic       g,
    output logic [3:0] gnt,
    output logic       busy
);

    localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(SETUP_CYCLES > 1 ? SETUP_CYCLES - 1 : 0);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);

    state_t               state, state_d;
    logic [1:0]           sel, sel_d, last, last_d, pick;
    logic                 any, g_q, g_d;
    logic [SETUP_W-1:0]   setup_cnt, setup_d;
    logic [HOLD_W-1:0]    hold_cnt, hold_d;
    logic [3:0]           req_c;

    // Unknown request bits never win arbitration.
    for (genvar i = 0; i < 4; i++) begin : g_req
        assign req_c[i] = (req[i] === 1'b1);
    end

    // Output delay is a simulation-only notion; synthesized outputs carry none.
    if (TCO != 0) begin : g_tco_sim_only
    end

    rr_pick4 u_pick (
        .req  (req_c),
        .last (last),
        .sel  (pick),
        .any  (any)
    );

    always_comb begin
        state_d = state;
        sel_d   = sel;
        last_d  = last;
        g_d     = g_q;
        setup_d = setup_cnt;
        hold_d  = hold_cnt;
        case (state)
            ST_IDLE: begin
                if (any) begin
                    state_d = ST_SETUP;
                    sel_d   = pick;
                    setup_d = '0;
                end
            end
            ST_SETUP: begin
                if (setup_cnt >= SETUP_LAST) begin
                    state_d = ST_ACTIVE;
                    g_d     = 1'b0;
                    hold_d  = '0;
                end else begin
                    setup_d = setup_cnt + 1'b1;
                end
            end
            ST_ACTIVE: begin
                hold_d = hold_cnt + 1'b1;
                if (!req_c[sel] || (MAX_HOLD != 0 && hold_cnt == HOLD_LAST)) begin
                    state_d = ST_RELEASE;
                    g_d     = 1'b1;
                    last_d  = sel;
                end
            end
            default: begin
                state_d = any ? ST_SETUP : ST_IDLE;
                sel_d   = any ? pick : sel;
                setup_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= ST_IDLE;
            sel       <= 2'd0;
            last      <= 2'd3;
            g_q       <= 1'b1;
            setup_cnt <= '0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_d;
            sel       <= sel_d;
            last      <= last_d;
            g_q       <= g_d;
            setup_cnt <= setup_d;
            hold_cnt  <= hold_d;
        end
    end

    assign {a1, a0} = sel;
    assign g        = g_q;
    assign gnt      = g_q ? 4'b0000 : (4'b0001 << sel);
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_mux4_rr_ctl.sv
// tb_mux4_rr_ctl: directed, table-driven checks of four differently parameterised schedulers.
module tb_mux4_rr_ctl;

    logic       clk = 1'b0;
    logic [3:0] req[4];
    logic       clr_n[4];
    logic       a1[4], a0[4], g[4], busy[4];
    logic [3:0] gnt[4];
    logic [1:0] prev_a[4] = '{default: 2'b00};
    int         checks = 0;
    int         fails  = 0;

    always #5 clk = ~clk;

    mux4_rr_ctl #(.SETUP_CYCLES(1), .MAX_HOLD(0)) u0 (.clk(clk), .clr_n(clr_n[0]), .req(req[0]),
        .a1(a1[0]), .a0(a0[0]), .g(g[0]), .gnt(gnt[0]), .busy(busy[0]));
    mux4_rr_ctl #(.SETUP_CYCLES(1), .MAX_HOLD(4)) u1 (.clk(clk), .clr_n(clr_n[1]), .req(req[1]),
        .a1(a1[1]), .a0(a0[1]), .g(g[1]), .gnt(gnt[1]), .busy(busy[1]));
    mux4_rr_ctl #(.SETUP_CYCLES(1), .MAX_HOLD(3)) u2 (.clk(clk), .clr_n(clr_n[2]), .req(req[2]),
        .a1(a1[2]), .a0(a0[2]), .g(g[2]), .gnt(gnt[2]), .busy(busy[2]));
    mux4_rr_ctl #(.SETUP_CYCLES(3), .MAX_HOLD(8)) u3 (.clk(clk), .clr_n(clr_n[3]), .req(req[3]),
        .a1(a1[3]), .a0(a0[3]), .g(g[3]), .gnt(gnt[3]), .busy(busy[3]));

    typedef struct {
        int         k;
        logic [3:0] req;
        logic [1:0] a;
        logic       g;
        logic [3:0] gnt;
        logic       busy;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input int k, input string nm, input logic [1:0] ea, input logic eg,
                       input logic [3:0] egnt, input logic eb);
        logic [7:0] act, exp;
        act = {a1[k], a0[k], g[k], gnt[k], busy[k]};
        exp = {ea, eg, egnt, eb};
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: a1a0_g_gnt_busy got %b required %b", nm, k, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Select must never move while the strobe is low; grant must agree with the strobe.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (({a1[k], a0[k]} != prev_a[k] && g[k] == 1'b0) || (g[k] && gnt[k] != 4'b0000) ||
                !$onehot0(gnt[k])) begin
                fails++;
                $display("FAIL invariant dut%0d: a1a0 %b prev %b g %b gnt %b", k,
                         {a1[k], a0[k]}, prev_a[k], g[k], gnt[k]);
            end
            prev_a[k] = {a1[k], a0[k]};
        end
    end

    initial begin
        tbl[0]  = '{0, 4'b0100, 2'b10, 1'b1, 4'b0000, 1'b1};
        tbl[1]  = '{0, 4'b0100, 2'b10, 1'b0, 4'b0100, 1'b1};
        tbl[2]  = '{0, 4'b0100, 2'b10, 1'b0, 4'b0100, 1'b1};
        tbl[3]  = '{0, 4'b0000, 2'b10, 1'b1, 4'b0000, 1'b1};
        tbl[4]  = '{0, 4'b0000, 2'b10, 1'b1, 4'b0000, 1'b0};
        tbl[5]  = '{3, 4'b1000, 2'b11, 1'b1, 4'b0000, 1'b1};
        tbl[6]  = '{3, 4'b0000, 2'b11, 1'b1, 4'b0000, 1'b1};
        tbl[7]  = '{3, 4'b0000, 2'b11, 1'b1, 4'b0000, 1'b1};
        tbl[8]  = '{3, 4'b0000, 2'b11, 1'b0, 4'b1000, 1'b1};
        tbl[9]  = '{3, 4'b0000, 2'b11, 1'b1, 4'b0000, 1'b1};
        tbl[10] = '{3, 4'b0000, 2'b11, 1'b1, 4'b0000, 1'b0};

        for (int k = 0; k < 4; k++) begin
            clr_n[k] = 1'b0;
            req[k]   = 4'b0000;
        end
        tick;
        tick;
        for (int k = 0; k < 4; k++) chk(k, "reset", 2'b00, 1'b1, 4'b0000, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) clr_n[k] = 1'b1;
        tick;

        for (int i = 0; i < 11; i++) begin
            req[tbl[i].k] = tbl[i].req;
            tick;
            chk(tbl[i].k, "table", tbl[i].a, tbl[i].g, tbl[i].gnt, tbl[i].busy);
        end

        req[0] = 4'b0100;
        tick;
        tick;
        chk(0, "pre_reset_active", 2'b10, 1'b0, 4'b0100, 1'b1);
        @(negedge clk);
        #1 clr_n[0] = 1'b0;
        #1 chk(0, "mid_grant_reset", 2'b00, 1'b1, 4'b0000, 1'b0);
        req[0] = 4'b0000;
        #1 clr_n[0] = 1'b1;

        tick;
        req[0] = 4'b0001;
        tick;
        tick;
        chk(0, "ignore_start", 2'b00, 1'b0, 4'b0001, 1'b1);
        for (int i = 0; i < 20; i++) begin
            req[0] = {3'($urandom_range(0, 7)), 1'b1};
            tick;
            chk(0, "ignore_others", 2'b00, 1'b0, 4'b0001, 1'b1);
        end
        req[0] = 4'b0000;
        tick;
        chk(0, "ignore_release", 2'b00, 1'b1, 4'b0000, 1'b1);
        tick;
        chk(0, "ignore_idle", 2'b00, 1'b1, 4'b0000, 1'b0);

        req[1] = 4'b1111;
        for (int c = 1; c < 30; c++) begin
            logic       lo;
            logic [1:0] s;
            tick;
            lo = (c >= 2) && ((c - 2) % 6 < 4);
            s  = 2'(((c - 1) / 6) % 4);
            chk(1, "round_robin", s, !lo, lo ? (4'b0001 << s) : 4'b0000, 1'b1);
        end
        req[1] = 4'b0000;

        req[2] = 4'b0010;
        for (int c = 1; c < 21; c++) begin
            logic lo;
            tick;
            lo = (c >= 2) && ((c - 2) % 5 < 3);
            chk(2, "sole_expiry", 2'b01, !lo, lo ? 4'b0010 : 4'b0000, 1'b1);
        end
        req[2] = 4'b0000;

        tick;
        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
